mem_read_arbiter: RTL and testbench

Two-port read arbiter and sequencer for the processor's shared single-port pipelined read memory (registered address, registered data, fixed read latency, data forced to zero when not reading). Accepts read requests from instruction fetch (IF) and data memory (DM) with valid/ready handshakes and issues at most one memory read per cycle. It tracks every in-flight read with a tag pipeline and steers the returned word to the requester that issued it. Sits between the core's fetch/load stages and the memory block.

---
 rtl/mem_read_arbiter.sv | 97 +++++++++
 tb/tb_mem_read_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - two-port (IF/DM) read arbiter and tag sequencer for a pipelined single-port memory
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise DM has fixed priority over IF.
module mem_read_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  input  logic              stall,
  input  logic              flush_if,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int   NSTG    = MEM_LAT + 1;
  localparam logic PORT_IF = 1'b0;

  logic            if_elig;
  logic            dm_elig;
  logic            grant_if;
  logic            grant_dm;
  logic [NSTG-1:0] tag_valid;
  logic [NSTG-1:0] tag_port;
  logic            last_valid;
  logic            last_port;

`ifdef MEM_ARB_RR_EN
  logic            prefer_dm;
`endif

  always_comb begin
    dm_elig = dm_req_valid && !stall;
    if_elig = if_req_valid && !stall && !flush_if;
`ifdef MEM_ARB_RR_EN
    grant_dm = dm_elig && (!if_elig || prefer_dm);
`else
    grant_dm = dm_elig;
`endif
    grant_if = if_elig && !grant_dm;
  end

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  // Tags shift every cycle: the memory never stalls, so neither may the tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_en <= 1'b0;
      mem_addr    <= '0;
      tag_valid   <= '0;
      tag_port    <= '0;
    end else begin
      mem_read_en <= grant_if || grant_dm;
      if (grant_dm)
        mem_addr <= dm_req_addr;
      else if (grant_if)
        mem_addr <= if_req_addr;
      tag_valid[0] <= grant_if || grant_dm;
      tag_port[0]  <= grant_dm;
      for (int i = 1; i < NSTG; i++) begin
        tag_valid[i] <= tag_valid[i-1] && !(flush_if && (tag_port[i-1] == PORT_IF));
        tag_port[i]  <= tag_port[i-1];
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prefer_dm <= 1'b1;
    else if (grant_dm)
      prefer_dm <= 1'b0;
    else if (grant_if)
      prefer_dm <= 1'b1;
  end
`endif

  assign last_valid   = tag_valid[NSTG-1];
  assign last_port    = tag_port[NSTG-1];
  assign if_rsp_valid = last_valid && (last_port == PORT_IF);
  assign dm_rsp_valid = last_valid && (last_port != PORT_IF);
  assign if_rsp_data  = if_rsp_valid ? mem_q : '0;
  assign dm_rsp_data  = dm_rsp_valid ? mem_q : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - directed-vector bench for mem_read_arbiter with a 2-cycle pipelined memory model
// Expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid;
  logic [AW-1:0] dm_req_addr;
  logic          dm_req_ready;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_data;
  logic          stall;
  logic          flush_if;
  logic          mem_read_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] mem_stage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .dm_req_valid (dm_req_valid),
    .dm_req_addr  (dm_req_addr),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_data  (dm_rsp_data),
    .stall        (stall),
    .flush_if     (flush_if),
    .mem_read_en  (mem_read_en),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q)
  );

  // Registered address, registered data, zero when not reading: two edges from read_en to q.
  always @(posedge clk) begin
    mem_stage <= mem_read_en ? mem[7'((mem_addr >> 2) & 32'h7f)] : '0;
    mem_q     <= mem_stage;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input string tag,
                           input logic ifv, input logic [31:0] ifa,
                           input logic dmv, input logic [31:0] dma,
                           input logic stl, input logic fl,
                           input logic e_ifr, input logic e_dmr,
                           input logic e_en, input logic [31:0] e_addr,
                           input logic e_ifv, input logic [31:0] e_ifd,
                           input logic e_dmv, input logic [31:0] e_dmd);
    if_req_valid = ifv;
    if_req_addr  = ifa;
    dm_req_valid = dmv;
    dm_req_addr  = dma;
    stall        = stl;
    flush_if     = fl;
    #1;
    check({tag, ".if_ready"}, 32'(if_req_ready), 32'(e_ifr));
    check({tag, ".dm_ready"}, 32'(dm_req_ready), 32'(e_dmr));
    check({tag, ".mem_en"},   32'(mem_read_en),  32'(e_en));
    if (e_en)
      check({tag, ".mem_addr"}, mem_addr, e_addr);
    check({tag, ".if_rsp_v"}, 32'(if_rsp_valid), 32'(e_ifv));
    check({tag, ".if_rsp_d"}, if_rsp_data, e_ifd);
    check({tag, ".dm_rsp_v"}, 32'(dm_rsp_valid), 32'(e_dmv));
    check({tag, ".dm_rsp_d"}, dm_rsp_data, e_dmd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".mem_en"},   32'(mem_read_en),  32'd0);
    check({tag, ".mem_addr"}, mem_addr,          32'd0);
    check({tag, ".if_rsp_v"}, 32'(if_rsp_valid), 32'd0);
    check({tag, ".if_rsp_d"}, if_rsp_data,       32'd0);
    check({tag, ".dm_rsp_v"}, 32'(dm_rsp_valid), 32'd0);
    check({tag, ".dm_rsp_d"}, dm_rsp_data,       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] gdm;
    int         j;

    for (int i = 0; i < 128; i++)
      mem[i] = 32'h1000_0000 | 32'(i);
    mem[4]  = 32'hDEAD_BEEF;
    mem[64] = 32'hCAFE_0100;

    rst_n        = 1'b0;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    dm_req_valid = 1'b0;
    dm_req_addr  = '0;
    stall        = 1'b0;
    flush_if     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single IF read: response exactly three cycles after acceptance.
    run_cycle("if1_0", 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("if1_1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    run_cycle("if1_2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("if1_3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    run_cycle("if1_4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both ports requesting four cycles: bit k set means row k grants DM.
    gdm = RR ? 4'b0101 : 4'b1111;
    for (int k = 0; k < 7; k++) begin
      logic e_ifr, e_dmr, e_en, e_ifv, e_dmv;
      logic [31:0] e_addr;
      e_dmr  = (k < 4) ? gdm[k] : 1'b0;
      e_ifr  = (k < 4) ? !gdm[k] : 1'b0;
      e_en   = (k >= 1) && (k <= 4);
      j      = k - 1;
      e_addr = (e_en && gdm[j]) ? 32'h100 : 32'h0;
      j      = k - 3;
      e_dmv  = (k >= 3) ? gdm[j] : 1'b0;
      e_ifv  = (k >= 3) ? !gdm[j] : 1'b0;
      run_cycle($sformatf("arb%0d", k), k < 4, 32'h0, k < 4, 32'h100, 0, 0,
                e_ifr, e_dmr, e_en, e_addr,
                e_ifv, e_ifv ? 32'h1000_0000 : 32'h0,
                e_dmv, e_dmv ? 32'hCAFE_0100 : 32'h0);
    end

    // Back-to-back DM reads of words 0, 1, 2.
    for (int k = 0; k < 7; k++) begin
      logic e_en, e_dmv;
      e_en  = (k >= 1) && (k <= 3);
      e_dmv = (k >= 3) && (k <= 5);
      run_cycle($sformatf("b2b%0d", k), 0, 0, k < 3, 32'(4 * k), 0, 0,
                0, k < 3, e_en, 32'(4 * (k - 1)),
                0, 0, e_dmv, e_dmv ? (32'h1000_0000 | 32'(k - 3)) : 32'h0);
    end

    // IF read flushed one cycle after grant; DM granted alongside the flush survives.
    run_cycle("fl0", 1, 32'h10, 0, 0,    0, 0, 1, 0, 0, 0,      0, 0, 0, 0);
    run_cycle("fl1", 1, 32'h10, 1, 32'h8, 0, 1, 0, 1, 1, 32'h10, 0, 0, 0, 0);
    run_cycle("fl2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0, 0);
    run_cycle("fl3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);
    run_cycle("fl4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 32'h1000_0002);
    run_cycle("fl5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);

    // Stall with both requesting; the read granted just before still returns.
    run_cycle("st0", 0, 0, 1, 32'h4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      run_cycle($sformatf("st%0d", k), 1, 32'h0, 1, 32'h100, 1, 0,
                0, 0, k == 1, 32'h4,
                0, 0, k == 3, (k == 3) ? 32'h1000_0001 : 32'h0);
    run_cycle("st6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with two reads in flight: immediate clear, nothing returns afterwards.
    run_cycle("rs0", 0, 0, 1, 32'h8, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0);
    run_cycle("rs1", 1, 32'h10, 0, 0, 0, 0, 1, 0, 1, 32'h8, 0, 0, 0, 0);
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_idle_outputs("rs_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 3; k <= 5; k++)
      run_cycle($sformatf("rs%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("rs6", 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0);
    run_cycle("rs7", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    run_cycle("rs8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0);
    run_cycle("rs9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 32'hDEAD_BEEF, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
